fp_div: RTL and testbench

FP_DIV -- requirements
Module: fp_div

---
 rtl/fp_div_pkg.sv | 20 ++
 rtl/fp_div_step.sv | 23 ++
 rtl/fp_div.sv | 129 ++++++++++++
 tb/tb_fp_div.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared fixed-point constants, divider state encoding and counter sizing helper.
// No logic of its own; imported by the fp_* blocks.
package fp_div_pkg;

  localparam int FP_WIDTH      = 32;
  localparam int FP_INT_WIDTH  = 16;
  localparam int FP_FRAC_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Counter must be able to hold the value ITERATIONS itself.
  function automatic int cnt_width(input int iterations);
    return $clog2(iterations + 1);
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: shift the next dividend bit in, subtract when it fits.
// Purely combinational, zero latency, no flow control.
module fp_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted = {rem_in, next_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    diff    = shifted[WIDTH:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[WIDTH:0];
  end

endmodule

// File: rtl/fp_div.sv
// Unsigned fixed-point divider, one restoring step per cycle; done pulses WIDTH+FRAC_WIDTH+1
// cycles after go (1 cycle on divide-by-zero). No backpressure: go is only accepted in IDLE.
module fp_div
  import fp_div_pkg::*;
#(
  parameter int WIDTH      = FP_WIDTH,
  parameter int INT_WIDTH  = FP_INT_WIDTH,
  parameter int FRAC_WIDTH = FP_FRAC_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int ITERATIONS = WIDTH + FRAC_WIDTH;
  localparam int CNT_W      = cnt_width(ITERATIONS);
  localparam int DVD_W      = WIDTH + FRAC_WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERATIONS - 1);

  if (WIDTH != INT_WIDTH + FRAC_WIDTH) begin : g_bad_format
    $error("fp_div: WIDTH must equal INT_WIDTH + FRAC_WIDTH");
  end

  div_state_t       state, state_nxt;
  logic [DVD_W-1:0] dividend;
  logic [DVD_W-1:0] quot;
  logic [DVD_W-1:0] quot_nxt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_nxt;
  logic [CNT_W-1:0] cnt;
  logic             q_bit;
  logic             start;
  logic             last_step;

  assign start     = (state == ST_IDLE) && go;
  assign last_step = (state == ST_RUN) && (cnt == LAST_STEP);
  assign quot_nxt  = {quot[DVD_W-2:0], q_bit};

  fp_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in   (rem),
    .divisor  (divisor),
    .next_bit (dividend[DVD_W-1]),
    .rem_out  (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = (right == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST_STEP) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    done = (state == ST_DONE);
  end

  // Iteration datapath: dividend streams out MSB first while the quotient streams in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
    end else if (start) begin
      dividend <= {left, {FRAC_WIDTH{1'b0}}};
      divisor  <= right;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
    end else if (state == ST_RUN) begin
      dividend <= {dividend[DVD_W-2:0], 1'b0};
      rem      <= rem_nxt;
      quot     <= quot_nxt;
      cnt      <= cnt + 1'b1;
    end
  end

  // Results are captured only on the edge that enters DONE, then held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_quotient  <= '0;
      out_remainder <= '0;
      div_by_zero   <= 1'b0;
      overflow      <= 1'b0;
    end else if (start && (right == '0)) begin
      out_quotient  <= '1;
      out_remainder <= left;
      div_by_zero   <= 1'b1;
      overflow      <= 1'b0;
    end else if (last_step) begin
      out_quotient  <= quot_nxt[WIDTH-1:0];
      out_remainder <= rem_nxt[WIDTH-1:0];
      div_by_zero   <= 1'b0;
      overflow      <= |quot_nxt[DVD_W-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: directed vectors, reset mid-operation, then random back-to-back ops.
// Expected results come from plain 64-bit integer division inside the bench.
module tb_fp_div;

  localparam int ITER  = 48;
  localparam int N_RND = 1000;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] left = '0;
  logic [31:0] right = '0;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t held = '{q: 32'h0, r: 32'h0, dbz: 1'b0, ovf: 1'b0, done_cyc: 0};
  exp_t me;

  fp_div #(
    .WIDTH      (32),
    .INT_WIDTH  (16),
    .FRAC_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // go_cyc is the cycle during which the DUT sits in IDLE with go high.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int go_cyc);
    exp_t e;
    logic [63:0] n;
    logic [63:0] qq;
    logic [63:0] rr;
    if (b == 32'h0) begin
      e.q        = 32'hFFFF_FFFF;
      e.r        = a;
      e.dbz      = 1'b1;
      e.ovf      = 1'b0;
      e.done_cyc = go_cyc + 1;
    end else begin
      n          = {16'h0, a, 16'h0};
      qq         = n / {32'h0, b};
      rr         = n % {32'h0, b};
      e.q        = qq[31:0];
      e.r        = rr[31:0];
      e.dbz      = 1'b0;
      e.ovf      = (qq[63:32] != 32'h0);
      e.done_cyc = go_cyc + ITER + 1;
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 96'(done), 96'(0));
        end else begin
          me = sbq.pop_front();
          check("quotient", 96'(out_quotient), 96'(me.q));
          check("remainder", 96'(out_remainder), 96'(me.r));
          check("div_by_zero", 96'(div_by_zero), 96'(me.dbz));
          check("overflow", 96'(overflow), 96'(me.ovf));
          check("done_cycle", 96'(cyc), 96'(me.done_cyc));
          held = me;
        end
      end else begin
        check("hold", {30'h0, out_quotient, out_remainder, div_by_zero, overflow},
                      {30'h0, held.q, held.r, held.dbz, held.ovf});
      end
    end
  end

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done) begin
      if (n == 150) begin
        checks++;
        errors++;
        $display("FAIL done_timeout at cycle %0d: no done within 150 cycles", cyc);
        finish_run();
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge with the DUT idle; leaves it idle again on return.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b);
    go    = 1'b1;
    left  = a;
    right = b;
    sbq.push_back(model(a, b, cyc));
    @(negedge clk);
    go    = 1'b0;
    left  = $urandom;
    right = $urandom;
    wait_done();
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_divisor();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'($urandom_range(1, 255));
      2:       return $urandom & 32'h0000_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_dividend();
    case ($urandom_range(0, 5))
      0:       return $urandom & 32'h0000_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int c0;

    #2;
    check("rst_quotient", 96'(out_quotient), 96'(0));
    check("rst_remainder", 96'(out_remainder), 96'(0));
    check("rst_flags", {93'h0, done, div_by_zero, overflow}, 96'(0));
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    run_single(32'h0006_0000, 32'h0002_0000);
    run_single(32'h0001_0000, 32'h0003_0000);
    run_single(32'h0005_0000, 32'h0000_0000);
    run_single(32'h8000_0000, 32'h0000_0001);
    run_single(32'h0000_0000, 32'h0000_0005);
    run_single(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_single(32'h0000_0001, 32'hFFFF_FFFF);
    run_single(32'h0000_0000, 32'h0000_0000);

    // Reset in the middle of an operation, with a stray go pulse while running.
    c0    = cyc;
    go    = 1'b1;
    left  = 32'h0006_0000;
    right = 32'h0002_0000;
    @(negedge clk);
    go = 1'b0;
    while (cyc < c0 + 10) @(negedge clk);
    go    = 1'b1;
    left  = 32'h0009_0000;
    right = 32'h0004_0000;
    @(negedge clk);
    go = 1'b0;
    while (cyc < c0 + 20) @(negedge clk);
    #2 reset_n = 1'b0;
    sbq.delete();
    held = '{q: 32'h0, r: 32'h0, dbz: 1'b0, ovf: 1'b0, done_cyc: 0};
    #1;
    check("midrst_quotient", 96'(out_quotient), 96'(0));
    check("midrst_remainder", 96'(out_remainder), 96'(0));
    check("midrst_flags", {93'h0, done, div_by_zero, overflow}, 96'(0));
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (60) @(negedge clk);
    run_single(32'h0001_0000, 32'h0003_0000);

    // Random operands with go held high; operands are scrambled once each op is taken.
    a     = rnd_dividend();
    b     = rnd_divisor();
    go    = 1'b1;
    left  = a;
    right = b;
    sbq.push_back(model(a, b, cyc));
    @(negedge clk);
    left  = $urandom;
    right = $urandom;
    for (int i = 1; i < N_RND; i++) begin
      wait_done();
      a     = rnd_dividend();
      b     = rnd_divisor();
      left  = a;
      right = b;
      sbq.push_back(model(a, b, cyc + 1));
      @(negedge clk);
      @(negedge clk);
      left  = $urandom;
      right = $urandom;
    end
    wait_done();
    go = 1'b0;
    repeat (5) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
    end
    finish_run();
  end

endmodule
